fetch_queue_stage: RTL and testbench
====================================

FETCH_QUEUE_STAGE -- requirements
Module: fetch_queue_stage

Interface
REQ-001 Parameter ADDR_W, default 9: PC/address width.
REQ-002 Parameter INSTR_W, default 33: instruction word width.
REQ-003 Parameter DEPTH, default 4: instruction queue entries (power of two, 2..16).
REQ-004 Parameter PC_STEP, default 1: PC increment per sequential fetch.
REQ-005 Parameter RESET_PC, default 0: PC loaded on reset.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset; asynchronous, active-high.
REQ-008 redirect_i  in  1  taken branch/jump from execute.
REQ-009 redirect_pc_i  in  ADDR_W  redirect target.
REQ-010 imem_en_o  out  1  instruction memory read request.
REQ-011 imem_addr_o  out  ADDR_W  read address; equals the fetch PC register.
REQ-012 imem_rdata_i  in  INSTR_W  read data, valid exactly 1 cycle after the request.
REQ-013 instr_o  out  INSTR_W  queue head instruction to decode.
REQ-014 pc_o  out  ADDR_W  PC of head entry.
REQ-015 pc_plus_o  out  ADDR_W  pc_o + PC_STEP, mod 2^ADDR_W.
REQ-016 valid_o  out  1  head entry valid.
REQ-017 ready_i  in  1  decode accepts head.
REQ-018 count_o  out  clog2(DEPTH)+1  queued entries.

Function
REQ-019 FSM states BOOT, RUN, REDIR; reset enters BOOT; BOOT -> RUN unconditionally after one cycle with no request issued.
REQ-020 In RUN, imem_en_o = 1 iff (count + inflight) < DEPTH, where inflight is the request issued in the previous cycle.
REQ-021 Each issued request advances fetch PC by PC_STEP, wrapping mod 2^ADDR_W (max address -> 0).
REQ-022 A non-discarded response is written to the queue tail with its PC at the end of the response cycle; issue -> valid_o latency is 2 cycles; no bypass.
REQ-023 Pop occurs when valid_o & ready_i; simultaneous push and pop leaves count unchanged, including when count = DEPTH.
REQ-024 Credit rule guarantees no push into a full queue; no overflow path exists.
REQ-025 valid_o = (count != 0); instr_o/pc_o are stable while valid_o=1 and ready_i=0.
REQ-026 redirect_i in any state: at next edge, queue cleared (count=0), fetch PC = redirect_pc_i, state = REDIR; a pop in the same cycle is discarded.
REQ-027 REDIR: response from the request issued in the redirect cycle is dropped; a request at the target is issued; -> RUN next cycle.
REQ-028 redirect_i while in REDIR restarts REDIR with the newer target; redirect_i takes priority over all other events.
REQ-029 Redirect at cycle t: target instruction on valid_o at t+3.

Reset
REQ-030 While rst=1: state BOOT, fetch PC=RESET_PC, count_o=0, valid_o=0, imem_en_o=0, inflight=0, queue pointers 0.
REQ-031 rst asserted mid-operation discards all queued and in-flight entries immediately.
REQ-032 Queue storage data is not reset; instr_o is don't-care when valid_o=0, pc_o=RESET_PC.

Structure
REQ-033 Package fetch_pkg holds fetch_state_t (BOOT/RUN/REDIR) and the default parameter constants.
REQ-034 Queue is sub-module fetch_fifo (DEPTH entries of {pc, instr}, flush input, wrapping read/write pointers).

Verification
REQ-035 Reset release, ready_i=1, memory word[a]=a+100 -> valid_o first at cycle 3 with pc_o=0, instr_o=100, then pc 1,2,3 each cycle.
REQ-036 ready_i=0 for 10 cycles -> count_o saturates at 4, imem_en_o=0, head stays pc 0; ready_i=1 -> pcs 0..7 in order, no loss or duplicate.
REQ-037 Redirect to 0x40 at cycle t with 3 entries queued -> count_o=0 at t+1, in-flight word dropped, valid_o with pc_o=0x40 at t+3.
REQ-038 Redirect at t and t+1 (targets 0x10, 0x20) -> 0x10 never appears; pc_o=0x20 at t+4.
REQ-039 Redirect to 0x1FE, ADDR_W=9 -> pcs 0x1FE, 0x1FF, 0x000; pc_plus_o at 0x1FF is 0x000.
REQ-040 rst pulse while queue full and request in flight -> count_o=0, valid_o=0 during reset; restart from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the fetch queue stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } fetch_state_t;

  localparam int ADDR_W_DEF   = 9;
  localparam int INSTR_W_DEF  = 33;
  localparam int DEPTH_DEF    = 4;
  localparam int PC_STEP_DEF  = 1;
  localparam int RESET_PC_DEF = 0;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue holding {pc, instr} pairs with a single-cycle flush.
module fetch_fifo #(
  parameter int AW    = 9,
  parameter int IW    = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [AW-1:0]            push_pc_i,
  input  logic [IW-1:0]            push_instr_i,
  input  logic                     pop_i,
  output logic [AW-1:0]            head_pc_o,
  output logic [IW-1:0]            head_instr_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] pc_mem_q  [DEPTH];
  logic [IW-1:0] ins_mem_q [DEPTH];

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  // Flush wins over both push and pop in the same cycle.
  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & (cnt_q != '0) & ~flush_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem_q[wr_q]  <= push_pc_i;
      ins_mem_q[wr_q] <= push_instr_i;
    end
  end

  assign head_pc_o    = pc_mem_q[rd_q];
  assign head_instr_o = ins_mem_q[rd_q];
  assign count_o      = cnt_q;

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: credit-based imem requests feeding an instruction queue.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int PC_STEP  = PC_STEP_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect_i,
  input  logic [ADDR_W-1:0]         redirect_pc_i,
  output logic                      imem_en_o,
  output logic [ADDR_W-1:0]         imem_addr_o,
  input  logic [INSTR_W-1:0]        imem_rdata_i,
  output logic [INSTR_W-1:0]        instr_o,
  output logic [ADDR_W-1:0]         pc_o,
  output logic [ADDR_W-1:0]         pc_plus_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              infl_q, infl_d;

  logic [CW-1:0]      cnt;
  logic [CW:0]        occ;
  logic               credit, req, pop;
  logic [ADDR_W-1:0]  head_pc;
  logic [INSTR_W-1:0] head_instr;

  // Queued plus in-flight entries must leave room for every response.
  assign occ    = {1'b0, cnt} + {{CW{1'b0}}, infl_q};
  assign credit = occ < (CW+1)'(DEPTH);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req     = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN, REDIR: begin
        req     = credit;
        state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
    if (req) pc_d = pc_q + ADDR_W'(PC_STEP);
    if (redirect_i) begin
      state_d = REDIR;
      pc_d    = redirect_pc_i;
    end
    // A request made alongside a redirect is on the wrong path.
    infl_d = req & ~redirect_i;
    ipc_d  = req ? pc_q : ipc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= ADDR_W'(RESET_PC);
      ipc_q   <= ADDR_W'(RESET_PC);
      infl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      infl_q  <= infl_d;
    end
  end

  assign pop = valid_o & ready_i;

  fetch_fifo #(
    .AW    (ADDR_W),
    .IW    (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect_i),
    .push_i       (infl_q),
    .push_pc_i    (ipc_q),
    .push_instr_i (imem_rdata_i),
    .pop_i        (pop),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr),
    .count_o      (cnt)
  );

  assign valid_o     = (cnt != '0);
  assign pc_o        = valid_o ? head_pc : ADDR_W'(RESET_PC);
  assign pc_plus_o   = pc_o + ADDR_W'(PC_STEP);
  assign instr_o     = head_instr;
  assign imem_en_o   = req;
  assign imem_addr_o = pc_q;
  assign count_o     = cnt;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: directed scenarios plus a random stream model.
module tb_fetch_queue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [8:0]  rpc = '0;
  logic        ready = 1'b0;
  logic        en;
  logic [8:0]  addr;
  logic [32:0] rdata = '0;
  logic [32:0] instr;
  logic [8:0]  pc;
  logic [8:0]  pcp;
  logic        valid;
  logic [2:0]  cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory: word[a] = a + 100; unrequested cycles return junk (bit 32 set).
  always @(posedge clk)
    rdata <= en ? 33'(addr) + 33'd100 : {1'b1, 32'($urandom)};

  fetch_queue_stage dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (rpc),
    .imem_en_o     (en),
    .imem_addr_o   (addr),
    .imem_rdata_i  (rdata),
    .instr_o       (instr),
    .pc_o          (pc),
    .pc_plus_o     (pcp),
    .valid_o       (valid),
    .ready_i       (ready),
    .count_o       (cnt)
  );

  function automatic logic [32:0] wd(input logic [8:0] a);
    return 33'(a) + 33'd100;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ready = 1'b0;
    nxt();
    nxt();
    smp();
    total++;
    if (cnt !== 3'd0) begin
      bad++; $display("FAIL rst_count got=%0d exp=0", cnt);
    end
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b exp=0", valid);
    end
    total++;
    if (en !== 1'b0) begin
      bad++; $display("FAIL rst_en got=%b exp=0", en);
    end
    total++;
    if (pc !== 9'd0) begin
      bad++; $display("FAIL rst_pc got=%h exp=0", pc);
    end
    total++;
    if (addr !== 9'd0) begin
      bad++; $display("FAIL rst_addr got=%h exp=0", addr);
    end
    nxt();
  endtask

  task automatic test_boot();
    ready = 1'b1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      smp();
      if (c == 0) begin
        total++;
        if (en !== 1'b0) begin
          bad++; $display("FAIL boot_en got=%b exp=0", en);
        end
      end
      if (c == 1) begin
        total++;
        if (en !== 1'b1 || addr !== 9'd0) begin
          bad++;
          $display("FAIL first_req got=%b/%h exp=1/000", en, addr);
        end
      end
      total++;
      if (valid !== (c >= 3)) begin
        bad++; $display("FAIL boot_valid c=%0d got=%b", c, valid);
      end
      if (c >= 3) begin
        total++;
        if (pc !== 9'(c - 3) || instr !== wd(9'(c - 3)) ||
            pcp !== 9'(c - 2)) begin
          bad++;
          $display("FAIL boot_head c=%0d got=%h/%0d/%h exp=%h",
                   c, pc, instr, pcp, 9'(c - 3));
        end
      end
      nxt();
    end
  endtask

  task automatic test_stall();
    int got;
    ready = 1'b0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      smp();
      if (c >= 3) begin
        total++;
        if (valid !== 1'b1 || pc !== 9'd0 || instr !== wd(9'd0)) begin
          bad++;
          $display("FAIL stall_head c=%0d got=%b/%h/%0d exp=1/000/100",
                   c, valid, pc, instr);
        end
      end
      if (c == 11) begin
        total++;
        if (cnt !== 3'd4 || en !== 1'b0) begin
          bad++;
          $display("FAIL stall_full got=%0d/%b exp=4/0", cnt, en);
        end
      end
      nxt();
    end
    ready = 1'b1;
    got = 0;
    for (int k = 0; k < 30 && got < 8; k++) begin
      smp();
      if (valid) begin
        total++;
        if (pc !== 9'(got) || instr !== wd(9'(got))) begin
          bad++;
          $display("FAIL drain got=%h/%0d exp=%h", pc, instr, 9'(got));
        end
        got++;
      end
      nxt();
    end
    total++;
    if (got != 8) begin
      bad++; $display("FAIL drain_count got=%0d exp=8", got);
    end
  endtask

  task automatic test_redirect();
    ready = 1'b0;
    do_reset();
    for (int c = 0; c < 5; c++) nxt();
    redirect = 1'b1;
    rpc = 9'h040;
    smp();
    total++;
    if (cnt !== 3'd3) begin
      bad++; $display("FAIL redir_setup got=%0d exp=3", cnt);
    end
    nxt();
    redirect = 1'b0;
    smp();
    total++;
    if (cnt !== 3'd0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_t1 got=%0d/%b exp=0/0", cnt, valid);
    end
    total++;
    if (en !== 1'b1 || addr !== 9'h040) begin
      bad++;
      $display("FAIL redir_req got=%b/%h exp=1/040", en, addr);
    end
    nxt();
    smp();
    total++;
    if (cnt !== 3'd0) begin
      bad++; $display("FAIL redir_drop got=%0d exp=0", cnt);
    end
    nxt();
    smp();
    total++;
    if (valid !== 1'b1 || pc !== 9'h040 || instr !== wd(9'h040)) begin
      bad++;
      $display("FAIL redir_t3 got=%b/%h/%0d exp=1/040", valid, pc, instr);
    end
    nxt();
  endtask

  task automatic test_back_to_back();
    ready = 1'b1;
    do_reset();
    for (int c = 0; c < 6; c++) nxt();
    redirect = 1'b1;
    rpc = 9'h010;
    nxt();
    rpc = 9'h020;
    nxt();
    redirect = 1'b0;
    for (int k = 2; k < 12; k++) begin
      smp();
      if (k < 4) begin
        total++;
        if (valid !== 1'b0) begin
          bad++; $display("FAIL b2b_gap k=%0d got=%b exp=0", k, valid);
        end
      end
      if (k == 4) begin
        total++;
        if (valid !== 1'b1 || pc !== 9'h020) begin
          bad++;
          $display("FAIL b2b_t4 got=%b/%h exp=1/020", valid, pc);
        end
      end
      if (valid) begin
        total++;
        if (pc === 9'h010) begin
          bad++; $display("FAIL b2b_stale got=%h exp!=010", pc);
        end
      end
      nxt();
    end
  endtask

  task automatic test_wrap();
    ready = 1'b1;
    redirect = 1'b1;
    rpc = 9'h1FE;
    nxt();
    redirect = 1'b0;
    nxt();
    nxt();
    smp();
    total++;
    if (valid !== 1'b1 || pc !== 9'h1FE || instr !== wd(9'h1FE)) begin
      bad++;
      $display("FAIL wrap_a got=%b/%h/%0d exp=1/1fe", valid, pc, instr);
    end
    nxt();
    smp();
    total++;
    if (pc !== 9'h1FF || pcp !== 9'h000) begin
      bad++; $display("FAIL wrap_b got=%h/%h exp=1ff/000", pc, pcp);
    end
    nxt();
    smp();
    total++;
    if (pc !== 9'h000 || pcp !== 9'h001 || instr !== wd(9'h000)) begin
      bad++;
      $display("FAIL wrap_c got=%h/%h/%0d exp=000/001/100", pc, pcp, instr);
    end
    nxt();
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    do_reset();
    for (int c = 0; c < 5; c++) nxt();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      smp();
      total++;
      if (cnt !== 3'd0 || valid !== 1'b0 || en !== 1'b0 ||
          pc !== 9'd0) begin
        bad++;
        $display("FAIL midrst got=%0d/%b/%b/%h exp=0/0/0/000",
                 cnt, valid, en, pc);
      end
      nxt();
    end
    rst = 1'b0;
    ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      smp();
      if (c >= 3) begin
        total++;
        if (valid !== 1'b1 || pc !== 9'(c - 3) || instr !== wd(9'(c - 3))) begin
          bad++;
          $display("FAIL midrst_restart c=%0d got=%b/%h", c, valid, pc);
        end
      end
      nxt();
    end
  endtask

  task automatic test_random();
    logic [8:0]  exp_pc;
    logic [8:0]  tgt;
    logic [8:0]  hold_pc;
    logic [32:0] hold_ins;
    logic        hold;
    int          last_t;
    ready = 1'b1;
    do_reset();
    exp_pc = 9'd0;
    tgt = 9'd0;
    hold = 1'b0;
    hold_pc = '0;
    hold_ins = '0;
    last_t = -100;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 19) == 0);
      rpc = 9'($urandom);
      smp();
      total++;
      if (valid !== (cnt != 3'd0) || cnt > 3'd4) begin
        bad++; $display("FAIL rnd_count got=%0d/%b", cnt, valid);
      end
      if (hold) begin
        total++;
        if (valid !== 1'b1 || pc !== hold_pc || instr !== hold_ins) begin
          bad++;
          $display("FAIL rnd_stable got=%b/%h exp=1/%h", valid, pc, hold_pc);
        end
      end
      if (cyc - last_t == 1 || cyc - last_t == 2) begin
        total++;
        if (valid !== 1'b0) begin
          bad++; $display("FAIL rnd_flush got=%b exp=0", valid);
        end
      end
      if (cyc - last_t == 3) begin
        total++;
        if (valid !== 1'b1 || pc !== tgt) begin
          bad++;
          $display("FAIL rnd_lat got=%b/%h exp=1/%h", valid, pc, tgt);
        end
      end
      if (!redirect && valid && ready) begin
        total++;
        if (pc !== exp_pc || instr !== wd(exp_pc) ||
            pcp !== 9'(exp_pc + 9'd1)) begin
          bad++;
          $display("FAIL rnd_pop got=%h/%0d/%h exp=%h",
                   pc, instr, pcp, exp_pc);
        end
        exp_pc = exp_pc + 9'd1;
      end
      if (redirect) begin
        exp_pc = rpc;
        tgt = rpc;
        last_t = cyc;
      end
      hold = valid & ~ready & ~redirect;
      hold_pc = pc;
      hold_ins = instr;
      nxt();
    end
    redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
